// File: rtl/delayed_sound_reader_if.sv
// Groups the writer-side strobe, the BRAM read port and the audio output of
// the delayed sound reader so they travel as one bundle.
// Modports: master = the reader (drives ram_* and audio_*), slave = the writer/BRAM/sink side.
interface delayed_sound_reader_if;
  logic        audio_valid_in;
  logic [15:0] wr_addr_in;
  logic        wr_active_in;
  logic [15:0] delay_in;
  logic [15:0] ram_addr_out;
  logic        ram_en_out;
  logic [15:0] ram_data_in;
  logic [15:0] audio_out;
  logic        audio_valid_out;
  logic        underrun_out;

  modport master (
    input  audio_valid_in, wr_addr_in, wr_active_in, delay_in, ram_data_in,
    output ram_addr_out, ram_en_out, audio_out, audio_valid_out, underrun_out
  );

  modport slave (
    output audio_valid_in, wr_addr_in, wr_active_in, delay_in, ram_data_in,
    input  ram_addr_out, ram_en_out, audio_out, audio_valid_out, underrun_out
  );
endinterface

// File: rtl/delayed_sound_reader.sv
// Reads a delayed sample out of a ring-buffer BRAM once per audio strobe.
// Latency: RAM_LATENCY+2 cycles strobe->audio_valid_out when served from BRAM, 1 cycle when silent.
// Backpressure: none; a strobe arriving while a BRAM read is outstanding is dropped.
// Ports: clk_in, rst_in (async active-low), bus (delayed_sound_reader_if.master):
//   strobe/wr_addr/wr_active/delay in, BRAM read port out/in, audio/valid/underrun out.
// Optional: define DELAY_FADE_EN to ramp the first 16 BRAM samples after priming by k/16.
module delayed_sound_reader #(
  parameter int RAM_DEPTH   = 48000,
  parameter int RAM_LATENCY = 2
) (
  input logic                    clk_in,
  input logic                    rst_in,
  delayed_sound_reader_if.master bus
);

  localparam logic [16:0] DEPTH = 17'(RAM_DEPTH);
  localparam logic [2:0]  LAT   = 3'(RAM_LATENCY);

  typedef enum logic [1:0] {PRIME, RUN, BUSY} state_t;

  state_t      state_q, state_d;
  logic [15:0] fill_q, fill_d, fill_inc;
  logic [2:0]  cnt_q, cnt_d;
  logic [15:0] ram_addr_q, ram_addr_d;
  logic        ram_en_q, ram_en_d;
  logic [15:0] audio_q, audio_d;
  logic        valid_q, valid_d;
  logic        underrun_q, underrun_d;
  logic [16:0] d_clamp, wr17, rd_addr;
  logic [15:0] sample_val;
  logic        rd_first, rd_done;
  logic        addr_unused;

  // Delay clamped into 1..RAM_DEPTH-1 so the read address never equals the write address.
  always_comb begin
    if (bus.delay_in == 16'd0)
      d_clamp = 17'd1;
    else if ({1'b0, bus.delay_in} >= DEPTH)
      d_clamp = DEPTH - 17'd1;
    else
      d_clamp = {1'b0, bus.delay_in};
  end

  // Ring-buffer wrap; the result is below RAM_DEPTH so bit 16 is always zero.
  assign wr17        = {1'b0, bus.wr_addr_in};
  assign rd_addr     = (wr17 >= d_clamp) ? (wr17 - d_clamp) : (wr17 + DEPTH - d_clamp);
  assign addr_unused = rd_addr[16];

  // Fill including the sample the writer stores on this very strobe.
  always_comb begin
    fill_inc = fill_q;
    if (bus.wr_active_in && ({1'b0, fill_q} < (DEPTH - 17'd1)))
      fill_inc = fill_q + 16'd1;
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    fill_d     = fill_q;
    ram_en_d   = 1'b0;
    ram_addr_d = ram_addr_q;
    audio_d    = audio_q;
    valid_d    = 1'b0;
    underrun_d = 1'b0;
    rd_first   = 1'b0;
    rd_done    = 1'b0;
    if (bus.audio_valid_in)
      fill_d = fill_inc;
    case (state_q)
      PRIME: begin
        if (bus.audio_valid_in) begin
          if ({1'b0, fill_inc} >= d_clamp) begin
            // Enough history: this strobe is already served from BRAM.
            ram_en_d   = 1'b1;
            ram_addr_d = rd_addr[15:0];
            cnt_d      = 3'd0;
            rd_first   = 1'b1;
            state_d    = BUSY;
          end else begin
            audio_d = 16'd0;
            valid_d = 1'b1;
          end
        end
      end
      RUN: begin
        if (bus.audio_valid_in) begin
          if (d_clamp > {1'b0, fill_inc}) begin
            // Delay grew past the stored history: emit silence and re-prime.
            audio_d    = 16'd0;
            valid_d    = 1'b1;
            underrun_d = 1'b1;
            state_d    = PRIME;
          end else begin
            ram_en_d   = 1'b1;
            ram_addr_d = rd_addr[15:0];
            cnt_d      = 3'd0;
            state_d    = BUSY;
          end
        end
      end
      BUSY: begin
        // Edge LAT+1 after the strobe edge is the one where the BRAM data is valid.
        if (cnt_q == LAT) begin
          audio_d = sample_val;
          valid_d = 1'b1;
          rd_done = 1'b1;
          state_d = RUN;
        end else begin
          cnt_d = cnt_q + 3'd1;
        end
      end
      default: state_d = PRIME;
    endcase
  end

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      state_q    <= PRIME;
      fill_q     <= 16'd0;
      cnt_q      <= 3'd0;
      ram_en_q   <= 1'b0;
      ram_addr_q <= 16'd0;
      audio_q    <= 16'd0;
      valid_q    <= 1'b0;
      underrun_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      fill_q     <= fill_d;
      cnt_q      <= cnt_d;
      ram_en_q   <= ram_en_d;
      ram_addr_q <= ram_addr_d;
      audio_q    <= audio_d;
      valid_q    <= valid_d;
      underrun_q <= underrun_d;
    end
  end

`ifdef DELAY_FADE_EN
  // Gain step k in 1..16; 16 is unity and is where the counter parks.
  logic [4:0]         fade_q;
  logic signed [20:0] data_ext, prod;
  logic               fade_unused;

  assign data_ext = 21'($signed(bus.ram_data_in));

  // data*k by shift-add; the >>>4 below floors toward negative infinity.
  always_comb begin
    prod = '0;
    for (int i = 0; i < 5; i++)
      if (fade_q[i])
        prod = prod + (data_ext <<< i);
  end

  assign sample_val  = prod[19:4];
  assign fade_unused = ^{prod[20], prod[3:0], rd_done, rd_first};

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in)
      fade_q <= 5'd16;
    else if (rd_first)
      fade_q <= 5'd1;
    else if (rd_done && (fade_q != 5'd16))
      fade_q <= fade_q + 5'd1;
  end
`else
  logic fade_unused;
  assign sample_val  = bus.ram_data_in;
  assign fade_unused = rd_first ^ rd_done;
`endif

  assign bus.ram_addr_out    = ram_addr_q;
  assign bus.ram_en_out      = ram_en_q;
  assign bus.audio_out       = audio_q;
  assign bus.audio_valid_out = valid_q;
  assign bus.underrun_out    = underrun_q;

endmodule

// File: doc/delayed_sound_reader.md
DELAYED_SOUND_READER -- requirements
Module: delayed_sound_reader

Interface
REQ-001 SHALL have parameter RAM_DEPTH, default 48000; ring-buffer depth in samples.
REQ-002 SHALL have parameter RAM_LATENCY, default 2; BRAM read latency in cycles, legal range 1..4.
REQ-003 SHALL have port clk_in, input, 1 bit; the single clock; all logic rises on its positive edge.
REQ-004 SHALL have port rst_in, input, 1 bit; reset, asynchronous, active-low.
REQ-005 SHALL have port audio_valid_in, input, 1 bit; sample strobe, one-cycle pulse.
REQ-006 SHALL have port wr_addr_in, input, 16 bits; writer's next write address, range 0..RAM_DEPTH-1.
REQ-007 SHALL have port wr_active_in, input, 1 bit; high when the writer stores this strobe's sample.
REQ-008 SHALL have port delay_in, input, 16 bits; requested delay in samples.
REQ-009 SHALL have port ram_addr_out, output, 16 bits; BRAM read-port address.
REQ-010 SHALL have port ram_en_out, output, 1 bit; BRAM read-port enable.
REQ-011 SHALL have port ram_data_in, input, 16 bits; BRAM read data, valid RAM_LATENCY cycles after ram_en_out.
REQ-012 SHALL have port audio_out, output, 16 bits; delayed sample, signed.
REQ-013 SHALL have port audio_valid_out, output, 1 bit; one-cycle pulse qualifying audio_out.
REQ-014 SHALL have port underrun_out, output, 1 bit; one-cycle pulse when a silent sample is substituted in RUN.

Function
REQ-015 SHALL sample delay_in only on audio_valid_in; 0 clamps to 1, values >= RAM_DEPTH clamp to RAM_DEPTH-1.
REQ-016 SHALL compute the read address in 17-bit arithmetic: wr_addr_in-d if wr_addr_in >= d, else wr_addr_in+RAM_DEPTH-d; the result is always < RAM_DEPTH.
REQ-017 SHALL keep a fill counter that increments on each audio_valid_in with wr_active_in high and saturates at RAM_DEPTH-1.
REQ-018 SHALL implement states PRIME, RUN and BUSY.
REQ-019 In PRIME, each strobe SHALL produce audio_out=0 with audio_valid_out one cycle later, and no BRAM read.
REQ-020 PRIME SHALL go to RUN on the strobe where fill >= d, and that strobe SHALL itself be served from BRAM.
REQ-021 In RUN, a strobe SHALL assert ram_en_out for exactly one cycle with the REQ-016 address and enter BUSY.
REQ-022 BUSY SHALL register ram_data_in RAM_LATENCY cycles after ram_en_out, pulse audio_valid_out on the next cycle, then return to RUN; total latency from strobe to audio_valid_out is RAM_LATENCY+2 cycles.
REQ-023 A strobe arriving in BUSY SHALL be dropped, with no output pulse and no fill change other than REQ-017.
REQ-024 In RUN, if the latched d exceeds fill (delay increased), the strobe SHALL output 0 with underrun_out, and the block SHALL return to PRIME.
REQ-025 A decrease of delay_in SHALL take effect on the next strobe with no PRIME.
REQ-026 audio_out SHALL hold its last value between pulses.

Reset
REQ-027 Asserting rst_in SHALL asynchronously force PRIME, fill=0, ram_en_out=0, ram_addr_out=0, audio_out=0, audio_valid_out=0 and underrun_out=0.
REQ-028 Reset asserted mid-BUSY SHALL discard the pending read; no audio_valid_out SHALL follow the release of reset.

Configuration
REQ-029 With DELAY_FADE_EN defined, the first 16 BRAM-served samples after each PRIME->RUN transition SHALL be scaled by k/16, k=1..16, using arithmetic shift-add with truncation toward negative infinity.
REQ-030 Without DELAY_FADE_EN, samples SHALL pass unscaled; the fade counter and its logic SHALL not exist.

Verification
REQ-031 Reset, delay_in=4, 3 strobes with wr_active_in=1 -> 3 zero outputs, no ram_en_out, state stays PRIME.
REQ-032 Continue with wr_addr_in=4 on the 4th strobe -> ram_addr_out=0, ram_en_out pulses, audio_valid_out occurs RAM_LATENCY+2 cycles after the strobe with audio_out=ram_data_in.
REQ-033 wr_addr_in=2, delay_in=5, RAM_DEPTH=48000 -> ram_addr_out=47997.
REQ-034 In RUN with fill=10, delay_in raised to 20 -> audio_out=0, underrun_out pulses, state goes to PRIME.
REQ-035 Strobes 2 cycles apart with RAM_LATENCY=2 -> the second strobe is dropped; exactly one audio_valid_out.
REQ-036 With DELAY_FADE_EN, constant ram_data_in=16'h1000 -> first outputs 16'h0100, 16'h0200, ..., with the 16th output 16'h1000.
